// File: rtl/lsu_stage.sv
// -----------------------------------------------------------------------------
// lsu_stage
//
// Multi-cycle load/store stage between the EX/MEM and MEM/WB pipeline
// registers. A memory instruction is captured in IDLE, presented on an
// external request/grant/response data bus, and its result is registered
// towards writeback. Byte enables and lane-replicated store data are formed
// at capture time. Loads select their byte lane and are sign- or
// zero-extended. Misaligned accesses, funct3 codes illegal for the
// configured XLEN, bus errors and bus timeouts all produce an exception
// result instead of a register write.
//
// Parameters
//   XLEN        : datapath/address width, 32 or 64
//   SIDE_W      : width of the opaque sideband carried to writeback
//   TIMEOUT_CYC : busy cycles before an access fault; 0 disables the timeout
//
// Ports
//   clk, reset            : clock; asynchronous active-low reset
//   in_*                  : instruction from EX/MEM (valid, read/write,
//                           reg_write, funct3, addr, wdata, rd, side)
//   stall_o               : upstream must hold its inputs while busy
//   bus_req/we/addr/be/wdata : request side of the data bus
//   bus_gnt/rvalid/rdata/err : grant and response side of the data bus
//   out_*                 : registered result to MEM/WB, including
//                           exception flag and 2-bit cause
// -----------------------------------------------------------------------------
module lsu_stage #(
  parameter int XLEN        = 32,
  parameter int SIDE_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic                in_mem_read,
  input  logic                in_mem_write,
  input  logic                in_reg_write,
  input  logic [2:0]          in_funct3,
  input  logic [XLEN-1:0]     in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  input  logic [4:0]          in_rd,
  input  logic [SIDE_W-1:0]   in_side,
  output logic                stall_o,
  output logic                bus_req,
  output logic                bus_we,
  output logic [XLEN-1:0]     bus_addr,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [XLEN-1:0]     bus_rdata,
  input  logic                bus_err,
  output logic                out_valid,
  output logic                out_reg_write,
  output logic [4:0]          out_rd,
  output logic [XLEN-1:0]     out_alu_result,
  output logic [XLEN-1:0]     out_load_data,
  output logic [SIDE_W-1:0]   out_side,
  output logic                out_exc,
  output logic [1:0]          out_exc_cause
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  // Wide enough to hold TIMEOUT_CYC, and at least one bit when it is 0.
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);

  localparam logic [1:0] CAUSE_LD_MIS = 2'b01;
  localparam logic [1:0] CAUSE_ST_MIS = 2'b10;
  localparam logic [1:0] CAUSE_FAULT  = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;

  // Captured access
  logic                 we_reg;
  logic                 reg_write_reg;
  logic [2:0]           funct3_reg;
  logic [OFF_W-1:0]     off_reg;
  logic [4:0]           rd_reg;
  logic [XLEN-1:0]      addr_reg;
  logic [SIDE_W-1:0]    side_reg;
  logic [XLEN-1:0]      bus_addr_reg;
  logic [BE_W-1:0]      be_reg;
  logic [XLEN-1:0]      wdata_reg;

  // Incoming-instruction decode
  logic                 in_mem;
  logic [OFF_W-1:0]     in_off;
  logic                 in_illegal;
  logic                 in_misaligned;
  logic [BE_W-1:0]      in_be;
  logic [XLEN-1:0]      in_wrep;

  // Load path
  logic [XLEN-1:0]      lane_data;
  logic [XLEN-1:0]      load_ext;

  // Next values of the writeback registers
  logic                 capture;
  logic                 done;
  logic                 done_err;
  logic                 timeout_hit;
  logic                 res_valid;
  logic                 res_reg_write;
  logic [4:0]           res_rd;
  logic [XLEN-1:0]      res_alu;
  logic [XLEN-1:0]      res_load;
  logic [SIDE_W-1:0]    res_side;
  logic                 res_exc;
  logic [1:0]           res_cause;

  assign in_mem = in_mem_read | in_mem_write;
  assign in_off = in_addr[OFF_W-1:0];

  // LD/SD/LWU exist only on a 64-bit datapath; the remaining undefined
  // funct3 codes are treated the same way so they never reach the bus.
  always_comb begin
    in_illegal = 1'b0;
    if (in_mem_write) begin
      in_illegal = in_funct3[2] || ((in_funct3[1:0] == 2'b11) && (XLEN != 64));
    end else begin
      case (in_funct3)
        3'b011, 3'b110: in_illegal = (XLEN != 64);
        3'b111:         in_illegal = 1'b1;
        default:        in_illegal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b01:   in_misaligned = in_addr[0];
      2'b10:   in_misaligned = |in_addr[1:0];
      2'b11:   in_misaligned = |in_addr[2:0];
      default: in_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b00:   in_be = BE_W'(1)  << in_off;
      2'b01:   in_be = BE_W'(3)  << in_off;
      2'b10:   in_be = BE_W'(15) << in_off;
      default: in_be = '1;
    endcase
  end

  // Store data: each byte lane picks the source byte that lands there when
  // the byte/half/word is repeated across the whole bus.
  for (genvar gi = 0; gi < BE_W; gi++) begin : g_wlane
    assign in_wrep[gi*8 +: 8] =
        (in_funct3[1:0] == 2'b00) ? in_wdata[7:0] :
        (in_funct3[1:0] == 2'b01) ? in_wdata[(gi % 2)*8 +: 8] :
        (in_funct3[1:0] == 2'b10) ? in_wdata[(gi % 4)*8 +: 8] :
                                    in_wdata[gi*8 +: 8];
  end

  // Load data: shift the addressed lane down to bit 0, then extend.
  assign lane_data = bus_rdata >> {off_reg, 3'b000};

  always_comb begin
    case (funct3_reg)
      3'b000:  load_ext = XLEN'($signed(lane_data[7:0]));
      3'b001:  load_ext = XLEN'($signed(lane_data[15:0]));
      3'b010:  load_ext = XLEN'($signed(lane_data[31:0]));
      3'b100:  load_ext = XLEN'(lane_data[7:0]);
      3'b101:  load_ext = XLEN'(lane_data[15:0]);
      3'b110:  load_ext = XLEN'(lane_data[31:0]);
      default: load_ext = lane_data;
    endcase
  end

  // cnt_reg counts completed busy cycles, so the current cycle is number
  // cnt_reg+1; the access is abandoned at the end of cycle TIMEOUT_CYC.
  assign timeout_hit = (TIMEOUT_CYC != 0) &&
                       ((32'(cnt_reg) + 32'd1) == $unsigned(32'(TIMEOUT_CYC)));

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    capture       = 1'b0;
    done          = 1'b0;
    done_err      = 1'b0;
    res_valid     = 1'b0;
    res_reg_write = 1'b0;
    res_rd        = rd_reg;
    res_alu       = addr_reg;
    res_load      = '0;
    res_side      = side_reg;
    res_exc       = 1'b0;
    res_cause     = 2'b00;

    case (state_reg)
      IDLE: begin
        cnt_next = '0;
        res_rd   = in_rd;
        res_alu  = in_addr;
        res_side = in_side;
        if (in_valid) begin
          if (!in_mem) begin
            res_valid     = 1'b1;
            res_reg_write = in_reg_write;
          end else if (in_illegal) begin
            res_valid = 1'b1;
            res_exc   = 1'b1;
            res_cause = CAUSE_FAULT;
          end else if (in_misaligned) begin
            res_valid = 1'b1;
            res_exc   = 1'b1;
            res_cause = in_mem_write ? CAUSE_ST_MIS : CAUSE_LD_MIS;
          end else begin
            capture    = 1'b1;
            state_next = REQ;
          end
        end
      end

      REQ: begin
        cnt_next = cnt_reg + CNT_W'(1);
        // A bus response beats a simultaneous timeout.
        if (bus_gnt && (we_reg || bus_rvalid)) begin
          done     = 1'b1;
          done_err = bus_err;
        end else if (bus_gnt) begin
          state_next = WAIT_RD;
        end else if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end

      WAIT_RD: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (bus_rvalid) begin
          done     = 1'b1;
          done_err = bus_err;
        end else if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (done) begin
      state_next = IDLE;
      cnt_next   = '0;
      res_valid  = 1'b1;
      if (done_err) begin
        res_exc   = 1'b1;
        res_cause = CAUSE_FAULT;
      end else begin
        res_reg_write = reg_write_reg;
        res_load      = we_reg ? '0 : load_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_reg        <= 1'b0;
      reg_write_reg <= 1'b0;
      funct3_reg    <= 3'b000;
      off_reg       <= '0;
      rd_reg        <= 5'd0;
      addr_reg      <= '0;
      side_reg      <= '0;
      bus_addr_reg  <= '0;
      be_reg        <= '0;
      wdata_reg     <= '0;
    end else if (capture) begin
      we_reg        <= in_mem_write;
      reg_write_reg <= in_reg_write;
      funct3_reg    <= in_funct3;
      off_reg       <= in_off;
      rd_reg        <= in_rd;
      addr_reg      <= in_addr;
      side_reg      <= in_side;
      bus_addr_reg  <= {in_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
      be_reg        <= in_be;
      wdata_reg     <= in_wrep;
    end
  end

  // out_valid is a one-cycle pulse; the data fields hold their last result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid      <= 1'b0;
      out_reg_write  <= 1'b0;
      out_rd         <= 5'd0;
      out_alu_result <= '0;
      out_load_data  <= '0;
      out_side       <= '0;
      out_exc        <= 1'b0;
      out_exc_cause  <= 2'b00;
    end else begin
      out_valid <= res_valid;
      if (res_valid) begin
        out_reg_write  <= res_reg_write;
        out_rd         <= res_rd;
        out_alu_result <= res_alu;
        out_load_data  <= res_load;
        out_side       <= res_side;
        out_exc        <= res_exc;
        out_exc_cause  <= res_cause;
      end
    end
  end

  // Bus request is decoded from the state register, so it falls as soon as
  // reset is asserted.
  assign bus_req   = (state_reg == REQ);
  assign bus_we    = bus_req & we_reg;
  assign bus_be    = bus_req ? be_reg : '0;
  assign bus_addr  = bus_addr_reg;
  assign bus_wdata = wdata_reg;
  assign stall_o   = (state_reg != IDLE);

endmodule

// File: tb/tb_lsu_stage.sv
module tb_lsu_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] side;
    logic [63:0] alu;
    logic [63:0] ld;
    logic        exc;
    logic [1:0]  cause;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  // ---------------- DUT A: XLEN=32, default timeout ----------------
  logic        a_rst_n = 1'b0;
  logic        a_in_valid = 0, a_in_mem_read = 0, a_in_mem_write = 0, a_in_reg_write = 0;
  logic [2:0]  a_in_funct3 = 0;
  logic [31:0] a_in_addr = 0, a_in_wdata = 0;
  logic [4:0]  a_in_rd = 0;
  logic [63:0] a_in_side = 0;
  logic        a_stall, a_bus_req, a_bus_we;
  logic [31:0] a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_be;
  logic        a_bus_gnt = 0, a_bus_rvalid = 0, a_bus_err = 0;
  logic [31:0] a_bus_rdata = 0;
  logic        a_out_valid, a_out_reg_write, a_out_exc;
  logic [4:0]  a_out_rd;
  logic [31:0] a_out_alu_result, a_out_load_data;
  logic [63:0] a_out_side;
  logic [1:0]  a_out_exc_cause;

  lsu_stage #(.XLEN(32), .SIDE_W(64), .TIMEOUT_CYC(255)) u_a (
    .clk(clk), .reset(a_rst_n),
    .in_valid(a_in_valid), .in_mem_read(a_in_mem_read), .in_mem_write(a_in_mem_write),
    .in_reg_write(a_in_reg_write), .in_funct3(a_in_funct3), .in_addr(a_in_addr),
    .in_wdata(a_in_wdata), .in_rd(a_in_rd), .in_side(a_in_side),
    .stall_o(a_stall), .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
    .bus_be(a_bus_be), .bus_wdata(a_bus_wdata), .bus_gnt(a_bus_gnt),
    .bus_rvalid(a_bus_rvalid), .bus_rdata(a_bus_rdata), .bus_err(a_bus_err),
    .out_valid(a_out_valid), .out_reg_write(a_out_reg_write), .out_rd(a_out_rd),
    .out_alu_result(a_out_alu_result), .out_load_data(a_out_load_data),
    .out_side(a_out_side), .out_exc(a_out_exc), .out_exc_cause(a_out_exc_cause)
  );

  // ---------------- DUT B: XLEN=64, TIMEOUT_CYC=4 ----------------
  logic        b_rst_n = 1'b0;
  logic        b_in_valid = 0, b_in_mem_read = 0, b_in_mem_write = 0, b_in_reg_write = 0;
  logic [2:0]  b_in_funct3 = 0;
  logic [63:0] b_in_addr = 0, b_in_wdata = 0;
  logic [4:0]  b_in_rd = 0;
  logic [63:0] b_in_side = 0;
  logic        b_stall, b_bus_req, b_bus_we;
  logic [63:0] b_bus_addr, b_bus_wdata;
  logic [7:0]  b_bus_be;
  logic        b_bus_gnt = 0, b_bus_rvalid = 0, b_bus_err = 0;
  logic [63:0] b_bus_rdata = 0;
  logic        b_out_valid, b_out_reg_write, b_out_exc;
  logic [4:0]  b_out_rd;
  logic [63:0] b_out_alu_result, b_out_load_data;
  logic [63:0] b_out_side;
  logic [1:0]  b_out_exc_cause;

  lsu_stage #(.XLEN(64), .SIDE_W(64), .TIMEOUT_CYC(4)) u_b (
    .clk(clk), .reset(b_rst_n),
    .in_valid(b_in_valid), .in_mem_read(b_in_mem_read), .in_mem_write(b_in_mem_write),
    .in_reg_write(b_in_reg_write), .in_funct3(b_in_funct3), .in_addr(b_in_addr),
    .in_wdata(b_in_wdata), .in_rd(b_in_rd), .in_side(b_in_side),
    .stall_o(b_stall), .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
    .bus_be(b_bus_be), .bus_wdata(b_bus_wdata), .bus_gnt(b_bus_gnt),
    .bus_rvalid(b_bus_rvalid), .bus_rdata(b_bus_rdata), .bus_err(b_bus_err),
    .out_valid(b_out_valid), .out_reg_write(b_out_reg_write), .out_rd(b_out_rd),
    .out_alu_result(b_out_alu_result), .out_load_data(b_out_load_data),
    .out_side(b_out_side), .out_exc(b_out_exc), .out_exc_cause(b_out_exc_cause)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one instruction into A (call at a negedge) and optionally queue
  // its hand-computed result.
  task automatic a_issue(input logic rd_op, input logic wr_op, input logic rw,
                         input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         input logic exp_rw, input logic [63:0] exp_ld,
                         input logic exp_exc, input logic [1:0] exp_cause,
                         input bit push);
    logic [63:0] side;
    side = {27'h5EED000, rd, addr};
    a_in_valid = 1'b1; a_in_mem_read = rd_op; a_in_mem_write = wr_op;
    a_in_reg_write = rw; a_in_funct3 = f3; a_in_addr = addr;
    a_in_wdata = wdata; a_in_rd = rd; a_in_side = side;
    if (push) qa.push_back('{exp_rw, rd, side, {32'd0, addr}, exp_ld, exp_exc, exp_cause});
  endtask

  task automatic b_issue(input logic rd_op, input logic wr_op, input logic rw,
                         input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd,
                         input logic exp_rw, input logic [63:0] exp_ld,
                         input logic exp_exc, input logic [1:0] exp_cause);
    logic [63:0] side;
    side = {27'h0B0B000, rd, addr[31:0]};
    b_in_valid = 1'b1; b_in_mem_read = rd_op; b_in_mem_write = wr_op;
    b_in_reg_write = rw; b_in_funct3 = f3; b_in_addr = addr;
    b_in_wdata = wdata; b_in_rd = rd; b_in_side = side;
    qb.push_back('{exp_rw, rd, side, addr, exp_ld, exp_exc, exp_cause});
  endtask

  // ---------------- monitors / scoreboards ----------------
  always @(negedge clk) begin : mon_a
    exp_t e;
    exp_t g;
    if (a_out_valid === 1'b1) begin
      g = {a_out_reg_write, a_out_rd, a_out_side, 64'(a_out_alu_result),
           64'(a_out_load_data), a_out_exc, a_out_exc_cause};
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_out_valid got out_valid=1 rd=%0d expected no result", a_out_rd);
      end else begin
        e = qa.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL a_result got rw=%0d rd=%0d alu=%h ld=%h exc=%0d cause=%0d side=%h expected rw=%0d rd=%0d alu=%h ld=%h exc=%0d cause=%0d side=%h",
                   g.rw, g.rd, g.alu, g.ld, g.exc, g.cause, g.side,
                   e.rw, e.rd, e.alu, e.ld, e.exc, e.cause, e.side);
        end else begin
          $display("a txn rd=%0d alu=%h ld=%h rw=%0d exc=%0d cause=%0d ok",
                   g.rd, g.alu, g.ld, g.rw, g.exc, g.cause);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    exp_t g;
    if (b_out_valid === 1'b1) begin
      g = {b_out_reg_write, b_out_rd, b_out_side, b_out_alu_result,
           b_out_load_data, b_out_exc, b_out_exc_cause};
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_out_valid got out_valid=1 rd=%0d expected no result", b_out_rd);
      end else begin
        e = qb.pop_front();
        if (g !== e) begin
          errors++;
          $display("FAIL b_result got rw=%0d rd=%0d alu=%h ld=%h exc=%0d cause=%0d side=%h expected rw=%0d rd=%0d alu=%h ld=%h exc=%0d cause=%0d side=%h",
                   g.rw, g.rd, g.alu, g.ld, g.exc, g.cause, g.side,
                   e.rw, e.rd, e.alu, e.ld, e.exc, e.cause, e.side);
        end else begin
          $display("b txn rd=%0d alu=%h ld=%h rw=%0d exc=%0d cause=%0d ok",
                   g.rd, g.alu, g.ld, g.rw, g.exc, g.cause);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    chk("a_rst_stall", 64'(a_stall), 0);
    chk("a_rst_bus_req", 64'(a_bus_req), 0);
    chk("a_rst_bus_we", 64'(a_bus_we), 0);
    chk("a_rst_bus_be", 64'(a_bus_be), 0);
    chk("a_rst_out_valid", 64'(a_out_valid), 0);
    chk("a_rst_out_exc", 64'(a_out_exc), 0);
    chk("a_rst_out_rw", 64'(a_out_reg_write), 0);
    chk("a_rst_load_data", 64'(a_out_load_data), 0);
    chk("b_rst_bus_req", 64'(b_bus_req), 0);
    chk("b_rst_bus_be", 64'(b_bus_be), 0);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;
    tick();

    // SB 0x1003, immediate grant
    a_issue(0, 1, 0, 3'b000, 32'h1003, 32'h0000_00A5, 5'd0, 0, 64'h0, 0, 2'b00, 1);
    tick(); a_in_valid = 0;
    chk("sb_req", 64'(a_bus_req), 1);
    chk("sb_we", 64'(a_bus_we), 1);
    chk("sb_be", 64'(a_bus_be), 64'b1000);
    chk("sb_wdata", 64'(a_bus_wdata), 64'hA5A5_A5A5);
    chk("sb_addr", 64'(a_bus_addr), 64'h1000);
    chk("sb_stall", 64'(a_stall), 1);
    a_bus_gnt = 1;
    tick(); a_bus_gnt = 0;
    chk("sb_latency_out_valid", 64'(a_out_valid), 1);
    chk("sb_done_stall", 64'(a_stall), 0);

    // LH 0x2002, rvalid 3 cycles after grant
    a_issue(1, 0, 1, 3'b001, 32'h2002, 32'h0, 5'd5, 1, 64'hFFFF_8001, 0, 2'b00, 1);
    tick(); a_in_valid = 0;
    chk("lh_req", 64'(a_bus_req), 1);
    chk("lh_we", 64'(a_bus_we), 0);
    chk("lh_be", 64'(a_bus_be), 64'b1100);
    chk("lh_addr", 64'(a_bus_addr), 64'h2000);
    a_bus_gnt = 1;
    tick(); a_bus_gnt = 0;
    chk("lh_wait_req", 64'(a_bus_req), 0);
    chk("lh_wait_stall1", 64'(a_stall), 1);
    tick();
    chk("lh_wait_stall2", 64'(a_stall), 1);
    tick();
    chk("lh_wait_stall3", 64'(a_stall), 1);
    a_bus_rvalid = 1; a_bus_rdata = 32'h8001_1234;
    tick(); a_bus_rvalid = 0;
    chk("lh_out_valid", 64'(a_out_valid), 1);
    chk("lh_done_stall", 64'(a_stall), 0);

    // LW 0x2001 misaligned -> cause 01
    a_issue(1, 0, 1, 3'b010, 32'h2001, 32'h0, 5'd6, 0, 64'h0, 1, 2'b01, 1);
    tick(); a_in_valid = 0;
    chk("lw_mis_no_req", 64'(a_bus_req), 0);
    chk("lw_mis_out_valid", 64'(a_out_valid), 1);

    // SW 0x2002 misaligned -> cause 10
    a_issue(0, 1, 0, 3'b010, 32'h2002, 32'h1234_5678, 5'd0, 0, 64'h0, 1, 2'b10, 1);
    tick(); a_in_valid = 0;
    chk("sw_mis_no_req", 64'(a_bus_req), 0);
    chk("sw_mis_out_valid", 64'(a_out_valid), 1);

    // LW 0x3000 with bus_err on rvalid -> cause 11
    a_issue(1, 0, 1, 3'b010, 32'h3000, 32'h0, 5'd7, 0, 64'h0, 1, 2'b11, 1);
    tick(); a_in_valid = 0;
    a_bus_gnt = 1;
    tick(); a_bus_gnt = 0;
    a_bus_rvalid = 1; a_bus_err = 1; a_bus_rdata = 32'h1234_5678;
    tick(); a_bus_rvalid = 0; a_bus_err = 0;

    // LD on XLEN=32 -> access fault, no request
    a_issue(1, 0, 1, 3'b011, 32'h0000_0040, 32'h0, 5'd9, 0, 64'h0, 1, 2'b11, 1);
    tick(); a_in_valid = 0;
    chk("ld32_no_req", 64'(a_bus_req), 0);

    // LB 0x4001 zero-wait bus -> 2-cycle latency, sign extended
    a_issue(1, 0, 1, 3'b000, 32'h4001, 32'h0, 5'd10, 1, 64'hFFFF_FFF0, 0, 2'b00, 1);
    tick(); a_in_valid = 0;
    a_bus_gnt = 1; a_bus_rvalid = 1; a_bus_rdata = 32'h0000_F000;
    tick(); a_bus_gnt = 0; a_bus_rvalid = 0;
    chk("lb_zero_wait_out_valid", 64'(a_out_valid), 1);

    // LBU 0x4001 zero extended
    a_issue(1, 0, 1, 3'b100, 32'h4001, 32'h0, 5'd11, 1, 64'h0000_00F0, 0, 2'b00, 1);
    tick(); a_in_valid = 0;
    a_bus_gnt = 1; a_bus_rvalid = 1; a_bus_rdata = 32'h0000_F000;
    tick(); a_bus_gnt = 0; a_bus_rvalid = 0;

    // Non-memory instruction, one-cycle latency
    a_issue(0, 0, 1, 3'b000, 32'h1234_5678, 32'h0, 5'd12, 1, 64'h0, 0, 2'b00, 1);
    tick(); a_in_valid = 0;
    chk("alu_out_valid", 64'(a_out_valid), 1);
    chk("alu_no_stall", 64'(a_stall), 0);

    // Reset while in REQ: bus_req must fall without a clock edge
    a_issue(0, 1, 0, 3'b010, 32'h6000, 32'hCAFE_F00D, 5'd0, 0, 64'h0, 0, 2'b00, 0);
    tick(); a_in_valid = 0;
    chk("rst_req_before", 64'(a_bus_req), 1);
    a_rst_n = 0;
    #1;
    chk("rst_req_async_drop", 64'(a_bus_req), 0);
    @(negedge clk);
    a_rst_n = 1;
    tick();

    // Reset while in WAIT_RD, late rvalid must be ignored
    a_issue(1, 0, 1, 3'b010, 32'h5000, 32'h0, 5'd13, 0, 64'h0, 0, 2'b00, 0);
    tick(); a_in_valid = 0;
    a_bus_gnt = 1;
    tick(); a_bus_gnt = 0;
    chk("rst_wait_stall_before", 64'(a_stall), 1);
    a_rst_n = 0;
    #1;
    chk("rst_wait_stall_async", 64'(a_stall), 0);
    @(negedge clk);
    a_rst_n = 1;
    tick();
    a_bus_rvalid = 1; a_bus_rdata = 32'hDEAD_BEEF;
    tick(); a_bus_rvalid = 0;
    chk("rst_late_rvalid_stall", 64'(a_stall), 0);
    tick();
    a_issue(0, 0, 1, 3'b000, 32'h0000_0ABC, 32'h0, 5'd14, 1, 64'h0, 0, 2'b00, 1);
    tick(); a_in_valid = 0;
    chk("after_rst_out_valid", 64'(a_out_valid), 1);

    // ---------------- XLEN=64 ----------------
    // LWU 0x8 -> zero-extended word
    b_issue(1, 0, 1, 3'b110, 64'h8, 64'h0, 5'd12, 1, 64'h0000_0000_8000_0000, 0, 2'b00);
    tick(); b_in_valid = 0;
    chk("lwu_req", 64'(b_bus_req), 1);
    chk("lwu_be", 64'(b_bus_be), 64'h0F);
    chk("lwu_addr", b_bus_addr, 64'h8);
    b_bus_gnt = 1; b_bus_rvalid = 1; b_bus_rdata = 64'hFFFF_FFFF_8000_0000;
    tick(); b_bus_gnt = 0; b_bus_rvalid = 0;
    chk("lwu_out_valid", 64'(b_out_valid), 1);

    // SD 0x10 -> all byte enables
    b_issue(0, 1, 0, 3'b011, 64'h10, 64'h1122_3344_5566_7788, 5'd0, 0, 64'h0, 0, 2'b00);
    tick(); b_in_valid = 0;
    chk("sd_be", 64'(b_bus_be), 64'hFF);
    chk("sd_wdata", b_bus_wdata, 64'h1122_3344_5566_7788);
    chk("sd_we", 64'(b_bus_we), 1);
    b_bus_gnt = 1;
    tick(); b_bus_gnt = 0;

    // SW 0x14 -> upper word lanes, word replicated
    b_issue(0, 1, 0, 3'b010, 64'h14, 64'h0000_0000_DEAD_BEEF, 5'd0, 0, 64'h0, 0, 2'b00);
    tick(); b_in_valid = 0;
    chk("sw64_be", 64'(b_bus_be), 64'hF0);
    chk("sw64_wdata", b_bus_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("sw64_addr", b_bus_addr, 64'h10);
    b_bus_gnt = 1;
    tick(); b_bus_gnt = 0;

    // LW 0x4 -> upper word, sign extended
    b_issue(1, 0, 1, 3'b010, 64'h4, 64'h0, 5'd15, 1, 64'hFFFF_FFFF_8000_0000, 0, 2'b00);
    tick(); b_in_valid = 0;
    b_bus_gnt = 1;
    tick(); b_bus_gnt = 0;
    b_bus_rvalid = 1; b_bus_rdata = 64'h8000_0000_1234_5678;
    tick(); b_bus_rvalid = 0;

    // SD 0x14 misaligned -> cause 10
    b_issue(0, 1, 0, 3'b011, 64'h14, 64'h0, 5'd0, 0, 64'h0, 1, 2'b10);
    tick(); b_in_valid = 0;
    chk("sd_mis_no_req", 64'(b_bus_req), 0);

    // Timeout: no grant ever, bus_req for exactly 4 cycles
    b_issue(1, 0, 1, 3'b010, 64'h20, 64'h0, 5'd16, 0, 64'h0, 1, 2'b11);
    tick(); b_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("timeout_req_cycle%0d", i), 64'(b_bus_req), 1);
      tick();
    end
    chk("timeout_req_dropped", 64'(b_bus_req), 0);
    chk("timeout_out_valid", 64'(b_out_valid), 1);
    chk("timeout_stall", 64'(b_stall), 0);

    repeat (3) tick();
    chk("a_queue_drained", 64'(qa.size()), 0);
    chk("b_queue_drained", 64'(qb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
# lsu_stage

Parametrised, multi-cycle successor to the single-cycle memory stage: sits between the EX/MEM and MEM/WB pipeline registers and drives an external data bus with a request/grant/response handshake instead of a zero-latency array. It generates byte enables and lane-replicated store data, sign/zero-extends loads, and supports XLEN 32 or 64. It also detects misalignment, bus errors and timeouts, and stalls the upstream pipeline while a bus access is outstanding. Outputs are registered and feed writeback directly.

## Interface
- XLEN, 32: datapath/address width; legal values 32, 64.
- SIDE_W, 64: width of opaque sideband (ResultSrc, PCPlus4, ImmExt) passed through unchanged.
- TIMEOUT_CYC, 255: max cycles waiting on the bus before an access fault; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction present.
- in_mem_read / in_mem_write  in  1 each  load / store; never both high.
- in_reg_write  in  1  writeback enable.
- in_funct3  in  3  access type (RISC-V load/store funct3).
- in_addr  in  XLEN  effective address (ALUResult).
- in_wdata  in  XLEN  store data.
- in_rd  in  5  destination register.
- in_side  in  SIDE_W  sideband.
- stall_o  out  1  upstream must hold its inputs.
- bus_req  out  1  request valid.
- bus_we  out  1  write request.
- bus_addr  out  XLEN  address with low log2(XLEN/8) bits zeroed.
- bus_be  out  XLEN/8  byte enables.
- bus_wdata  out  XLEN  lane-replicated store data.
- bus_gnt  in  1  request accepted.
- bus_rvalid  in  1  read data valid.
- bus_rdata  in  XLEN  read data.
- bus_err  in  1  error, qualified by bus_gnt (stores) or bus_rvalid (loads).
- out_valid, out_reg_write, out_rd, out_alu_result, out_load_data, out_side  out  registered to WB.
- out_exc  out  1  exception.
- out_exc_cause  out  2  01 load misaligned, 10 store misaligned, 11 access fault.

## Operation
- FSM states: IDLE, REQ, WAIT_RD.
- IDLE, in_valid, no memory op: outputs registered next edge.
- IDLE, aligned memory op: capture inputs, go to REQ.
- Misaligned memory op: no bus request; exception result next edge, stays IDLE.
- Misalignment rules: halfword needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- REQ: bus_req=1 and bus fields held stable until bus_gnt.
  - Store + gnt: complete, go to IDLE.
  - Load + gnt + rvalid in the same cycle: complete, go to IDLE.
  - Load + gnt only: go to WAIT_RD.
- WAIT_RD: complete on bus_rvalid, go to IDLE.
- stall_o = (state != IDLE). The accepting cycle is not stalled; the next instruction is held while busy.
- Byte enables: SB 1<<off; SH 3<<off; SW 0xF<<off, where off = addr[log2(XLEN/8)-1:0]; SD all ones.
- Store data replication: byte, half or word replicated across all lanes.
- Loads select the lane at off, then extend:
  - LB/LH/LW: sign-extend to XLEN.
  - LBU/LHU/LWU: zero-extend.
  - LD: passes data through.
- funct3 011 (LD/SD) and 110 (LWU) are legal only when XLEN=64.
  - When XLEN=32 they raise access fault (cause 11) with no bus request.
- bus_err on completion: out_exc=1, cause 11.
- Timeout: counter increments each cycle in REQ or WAIT_RD and clears on entering IDLE. Reaching TIMEOUT_CYC gives cause 11, drops bus_req and returns to IDLE.
- Any exception forces out_reg_write=0 and out_load_data=0. rd, alu_result and side still pass through.
- bus_rvalid or bus_gnt in IDLE is ignored.

## Timing
- Reset values: state IDLE, stall_o 0, bus_req 0, bus_we 0, bus_be 0, out_valid 0, out_exc 0, out_reg_write 0, timeout counter 0; data outputs 0.
- Reset mid-access: bus_req drops asynchronously; the in-flight instruction is discarded with no out_valid.
- Latency, in_valid to out_valid:
  - Non-memory or misaligned: 1 cycle.
  - Store: 1 + grant wait + 1.
  - Load: 1 + cycles to rvalid + 1.
- Zero-wait bus (gnt and rvalid in the first REQ cycle): 2 cycles.
- out_valid pulses exactly one cycle per accepted instruction; it is 0 for bubbles.

## Test plan
- XLEN=32, SB addr 0x1003 data 0xA5, gnt immediate -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000; out_valid 2 cycles after accept.
- LH addr 0x2002, rvalid 3 cycles after gnt, rdata 0x8001_1234 -> stall_o high throughout; out_load_data=0xFFFF8001, out_reg_write=1.
- LW addr 0x2001 -> no bus_req; next cycle out_exc=1, cause 01, out_reg_write=0. SW addr 0x2002 -> cause 10.
- Load with bus_err on rvalid -> cause 11, out_reg_write=0. TIMEOUT_CYC=4 with gnt never asserted -> cause 11 after 4 REQ cycles, bus_req dropped.
- XLEN=64: LWU addr 0x8 rdata 0xFFFFFFFF_80000000 -> 0x00000000_80000000; SD addr 0x10 -> bus_be=0xFF. XLEN=32 LD -> cause 11.
- reset low while in WAIT_RD, then rvalid after release -> no out_valid, stall_o 0, next instruction proceeds normally.
